// File: rtl/llbit_ctrl_mh.sv
// Per-hart LL/SC reservation tracker with cross-hart snoop invalidation and optional timeout.
// sc_ok is combinational (zero latency); state updates on the next clk edge; no backpressure.
module llbit_ctrl_mh #(
  parameter int NUM_HARTS = 2,
  parameter int ADDR_W    = 32,
  parameter int LINE_OFS  = 4,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 11
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_HARTS-1:0]        csrwr_en,
  input  logic [3*NUM_HARTS-1:0]      csrwr_data,
  input  logic [NUM_HARTS-1:0]        ll_valid,
  input  logic [ADDR_W*NUM_HARTS-1:0] ll_addr,
  input  logic [NUM_HARTS-1:0]        sc_valid,
  input  logic [ADDR_W*NUM_HARTS-1:0] sc_addr,
  input  logic [NUM_HARTS-1:0]        ertn,
  input  logic                        snoop_valid,
  input  logic [ADDR_W-1:0]           snoop_addr,
  input  logic [NUM_HARTS-1:0]        snoop_src,
  output logic [NUM_HARTS-1:0]        sc_ok,
  output logic [32*NUM_HARTS-1:0]     llbctl
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic unused_snoop;
  assign unused_snoop = ^snoop_addr;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    logic              llbit_q;
    logic              klo_q;
    logic [ADDR_W-1:0] resaddr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [2:0]        wr_dat;
    logic [ADDR_W-1:0] ll_a;
    logic [ADDR_W-1:0] sc_a;
    logic              sc_hit;
    logic              snoop_hit;
    logic              tmo_exp;
    logic              clr;
    logic              unused_h;

    assign wr_dat = csrwr_data[3*h +: 3];
    assign ll_a   = ll_addr[ADDR_W*h +: ADDR_W];
    assign sc_a   = sc_addr[ADDR_W*h +: ADDR_W];

    assign sc_hit    = (sc_a[ADDR_W-1:LINE_OFS] == resaddr_q[ADDR_W-1:LINE_OFS]);
    assign snoop_hit = (snoop_addr[ADDR_W-1:LINE_OFS] == resaddr_q[ADDR_W-1:LINE_OFS]);
    assign tmo_exp   = (TIMEOUT > 0) && llbit_q && (cnt_q == CNT_ONE);

    // Any clear beats a same-cycle LL; ERTN only kills LLBit when KLO was not armed.
    assign clr = sc_valid[h]
               | (csrwr_en[h] & wr_dat[1])
               | (ertn[h] & ~klo_q)
               | (snoop_valid & ~snoop_src[h] & snoop_hit & llbit_q)
               | tmo_exp;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        llbit_q   <= 1'b0;
        klo_q     <= 1'b0;
        resaddr_q <= '0;
        cnt_q     <= '0;
      end else begin
        if (clr)
          llbit_q <= 1'b0;
        else if (ll_valid[h])
          llbit_q <= 1'b1;

        if (ll_valid[h])
          resaddr_q <= ll_a;

        if (csrwr_en[h])
          klo_q <= wr_dat[2];
        else if (ertn[h] && klo_q)
          klo_q <= 1'b0;

        if (TIMEOUT == 0)
          cnt_q <= '0;
        else if (ll_valid[h])
          cnt_q <= CNT_LOAD;
        else if (tmo_exp)
          cnt_q <= '0;
        else if (llbit_q && (cnt_q > CNT_ONE))
          cnt_q <= cnt_q - CNT_ONE;
      end
    end

    assign sc_ok[h]           = llbit_q & sc_valid[h] & sc_hit;
    assign llbctl[32*h +: 32] = {29'b0, klo_q, 1'b0, llbit_q};

    // ROLLB and the in-line offset bits never influence the result.
    assign unused_h = ^{wr_dat[0], sc_a, resaddr_q};
  end

endmodule

// File: tb/tb_llbit_ctrl_mh.sv
module tb_llbit_ctrl_mh;

  localparam int NH = 2;
  localparam int AW = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NH-1:0]  csrwr_en;
  logic [3*NH-1:0] csrwr_data;
  logic [NH-1:0]  ll_valid;
  logic [AW*NH-1:0] ll_addr;
  logic [NH-1:0]  sc_valid;
  logic [AW*NH-1:0] sc_addr;
  logic [NH-1:0]  ertn;
  logic           snoop_valid;
  logic [AW-1:0]  snoop_addr;
  logic [NH-1:0]  snoop_src;

  logic [NH-1:0]    sc_ok_m, sc_ok_t4, sc_ok_t0;
  logic [32*NH-1:0] llbctl_m, llbctl_t4, llbctl_t0;

  always #5 clk = ~clk;

  llbit_ctrl_mh #(.NUM_HARTS(NH), .ADDR_W(AW), .LINE_OFS(4), .TIMEOUT(1024), .CNT_W(11)) u_main (
    .clk(clk), .rst_n(rst_n), .csrwr_en(csrwr_en), .csrwr_data(csrwr_data),
    .ll_valid(ll_valid), .ll_addr(ll_addr), .sc_valid(sc_valid), .sc_addr(sc_addr),
    .ertn(ertn), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_src(snoop_src),
    .sc_ok(sc_ok_m), .llbctl(llbctl_m));

  llbit_ctrl_mh #(.NUM_HARTS(NH), .ADDR_W(AW), .LINE_OFS(4), .TIMEOUT(4), .CNT_W(3)) u_t4 (
    .clk(clk), .rst_n(rst_n), .csrwr_en(csrwr_en), .csrwr_data(csrwr_data),
    .ll_valid(ll_valid), .ll_addr(ll_addr), .sc_valid(sc_valid), .sc_addr(sc_addr),
    .ertn(ertn), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_src(snoop_src),
    .sc_ok(sc_ok_t4), .llbctl(llbctl_t4));

  llbit_ctrl_mh #(.NUM_HARTS(NH), .ADDR_W(AW), .LINE_OFS(4), .TIMEOUT(0), .CNT_W(11)) u_t0 (
    .clk(clk), .rst_n(rst_n), .csrwr_en(csrwr_en), .csrwr_data(csrwr_data),
    .ll_valid(ll_valid), .ll_addr(ll_addr), .sc_valid(sc_valid), .sc_addr(sc_addr),
    .ertn(ertn), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .snoop_src(snoop_src),
    .sc_ok(sc_ok_t0), .llbctl(llbctl_t0));

  // Observation points: 0/1 main llbctl h0/h1, 2 main sc_ok, 3 t4 llbctl h0, 4 t0 llbctl h0
  typedef struct {
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      0:       return llbctl_m[31:0];
      1:       return llbctl_m[63:32];
      2:       return {30'b0, sc_ok_m};
      3:       return llbctl_t4[31:0];
      4:       return llbctl_t0[31:0];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e   = exp_q.pop_front();
      act = observe(e.sel);
      n_checks++;
      if (act !== e.val) begin
        n_errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_v(int sel, logic [31:0] v, string nm);
    exp_q.push_back('{sel, v, nm});
  endtask

  task automatic clr_in();
    csrwr_en    = '0;
    csrwr_data  = '0;
    ll_valid    = '0;
    ll_addr     = '0;
    sc_valid    = '0;
    sc_addr     = '0;
    ertn        = '0;
    snoop_valid = 1'b0;
    snoop_addr  = '0;
    snoop_src   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr_in();
  endtask

  task automatic do_ll(int h, logic [31:0] a);
    ll_valid[h]        = 1'b1;
    ll_addr[h*AW +: AW] = a;
  endtask

  task automatic do_sc(int h, logic [31:0] a);
    sc_valid[h]        = 1'b1;
    sc_addr[h*AW +: AW] = a;
  endtask

  task automatic do_csr(int h, logic [2:0] d);
    csrwr_en[h]        = 1'b1;
    csrwr_data[h*3 +: 3] = d;
  endtask

  task automatic do_snoop(logic [31:0] a, logic [NH-1:0] src);
    snoop_valid = 1'b1;
    snoop_addr  = a;
    snoop_src   = src;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in();
    repeat (2) @(posedge clk);
    #1;
    do_sc(0, 32'h0); do_sc(1, 32'h0);
    expect_v(0, 32'h0, "reset_llbctl0");
    expect_v(1, 32'h0, "reset_llbctl1");
    expect_v(2, 32'h0, "reset_sc_ok");
    step();
    rst_n = 1'b1;

    // basic LL/SC within the same 16-byte line
    do_ll(0, 32'h1000_0040);
    step();
    do_sc(0, 32'h1000_004C);
    expect_v(2, 32'h1, "sc_same_line");
    expect_v(0, 32'h1, "ll_sets_llbit");
    step();
    expect_v(0, 32'h0, "sc_clears_llbit");

    // foreign store on the reserved line kills it
    do_ll(0, 32'h2000);
    step();
    do_snoop(32'h2008, 2'b10);
    expect_v(0, 32'h1, "pre_snoop_llbit");
    step();
    expect_v(0, 32'h0, "snoop_other_clears");
    do_sc(0, 32'h2000);
    expect_v(2, 32'h0, "sc_after_snoop_fails");
    step();

    // own store does not
    do_ll(0, 32'h2000);
    step();
    do_snoop(32'h2008, 2'b01);
    step();
    expect_v(0, 32'h1, "snoop_self_keeps");
    do_sc(0, 32'h2000);
    expect_v(2, 32'h1, "sc_after_self_snoop");
    step();

    // different line, no effect on h1
    do_ll(1, 32'h4000);
    step();
    do_snoop(32'h4010, 2'b01);
    step();
    expect_v(1, 32'h1, "snoop_other_line_keeps");
    do_sc(1, 32'h4100);
    expect_v(2, 32'h0, "sc_wrong_line_fails");
    step();
    expect_v(1, 32'h0, "failed_sc_still_clears");

    // SC on h0 and h0's store snooping h1 in the same cycle
    do_ll(0, 32'h3000); do_ll(1, 32'h3004);
    step();
    do_sc(0, 32'h3000);
    do_snoop(32'h3000, 2'b01);
    expect_v(2, 32'h1, "sc_with_concurrent_snoop");
    step();
    expect_v(0, 32'h0, "sc_h0_cleared");
    expect_v(1, 32'h0, "snoop_h1_cleared");

    // KLO preserves LLBit across one ERTN
    do_csr(0, 3'b100);
    step();
    expect_v(0, 32'h4, "klo_written");
    do_ll(0, 32'h5000);
    step();
    expect_v(0, 32'h5, "klo_and_llbit");
    ertn[0] = 1'b1;
    step();
    expect_v(0, 32'h1, "ertn_klo_keeps_llbit");
    ertn[0] = 1'b1;
    step();
    expect_v(0, 32'h0, "second_ertn_clears");

    // CSR write beats a simultaneous ERTN for KLO
    do_csr(0, 3'b100);
    ertn[0] = 1'b1;
    step();
    expect_v(0, 32'h4, "csrwr_wins_over_ertn");
    do_csr(0, 3'b000);
    step();
    expect_v(0, 32'h0, "klo_cleared_by_write");

    // LL together with WCLLB: clear wins
    do_ll(1, 32'h6000);
    do_csr(1, 3'b010);
    step();
    expect_v(1, 32'h0, "ll_with_wcllb");
    do_sc(1, 32'h6000);
    expect_v(2, 32'h0, "sc_after_ll_wcllb");
    step();

    // ROLLB-only write is ignored; WCLLB reads back 0
    do_ll(1, 32'h7000);
    step();
    do_csr(1, 3'b001);
    step();
    expect_v(1, 32'h1, "rollb_ignored");
    do_csr(1, 3'b010);
    step();
    expect_v(1, 32'h0, "wcllb_clears_reads_0");

    // reset mid-reservation with KLO on both harts
    do_csr(0, 3'b100); do_csr(1, 3'b100);
    step();
    do_ll(0, 32'h8000); do_ll(1, 32'h8000);
    step();
    expect_v(0, 32'h5, "prereset_h0");
    expect_v(1, 32'h5, "prereset_h1");
    rst_n = 1'b0;
    step();
    expect_v(0, 32'h0, "midreset_h0");
    expect_v(1, 32'h0, "midreset_h1");
    rst_n = 1'b1;
    do_sc(0, 32'h8000); do_sc(1, 32'h8000);
    expect_v(2, 32'h0, "sc_after_reset");
    step();

    // TIMEOUT=4: set at edge 0, alive through edge 3, gone at edge 4
    do_ll(0, 32'h9000);
    step();
    for (int k = 0; k <= 4; k++) begin
      expect_v(3, (k < 4) ? 32'h1 : 32'h0, $sformatf("timeout4_edge%0d", k));
      if (k < 4) step();
    end
    step();

    // a second LL reloads the counter
    do_ll(0, 32'hA000);
    step();
    step();
    do_ll(0, 32'hA000);
    step();
    for (int k = 2; k <= 6; k++) begin
      expect_v(3, (k < 6) ? 32'h1 : 32'h0, $sformatf("reload_edge%0d", k));
      if (k < 6) step();
    end
    step();

    // TIMEOUT=0 never expires
    do_ll(0, 32'hB000);
    step();
    repeat (5000) step();
    expect_v(4, 32'h1, "timeout0_holds");
    step();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
